// File: rtl/fp_pipe_pkg.sv
// Shared types and helpers for the pipelined FP normalise/round datapath.
// FP_WORD_T builds a {sign, exp, frac} word type for any exponent/fraction width.
`ifndef FP_PIPE_PKG_SV
`define FP_PIPE_PKG_SV
`define FP_WORD_T(EW, MW) struct packed { logic sign; logic [(EW)-1:0] exp; logic [(MW)-1:0] frac; }

package fp_pipe_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rm_e;

  localparam int unsigned DEF_EXP_W = 8;
  localparam int unsigned DEF_MAN_W = 23;
  localparam int unsigned EXP_MAX   = (1 << DEF_EXP_W) - 1;

  typedef `FP_WORD_T(DEF_EXP_W, DEF_MAN_W) fp32_t;

  // Whether the truncated magnitude must be bumped by one ulp.
  function automatic logic round_incr(input rm_e rm, input logic sign, input logic lsb,
                                      input logic g, input logic r, input logic s);
    logic incr;
    incr = 1'b0;
    unique case (rm)
      RNE: incr = g & (r | s | lsb);
      RTZ: incr = 1'b0;
      RUP: incr = !sign & (g | r | s);
      RDN: incr = sign & (g | r | s);
    endcase
    return incr;
  endfunction

endpackage
`endif

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module fp_lzc #(
  parameter  int unsigned W     = 26,
  localparam int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     value,
  output logic [CNT_W-1:0] count
);

  logic found;

  always_comb begin
    count = CNT_W'(W);
    found = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = CNT_W'(int'(W) - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normaliser/rounder for IEEE-754 binary formats with valid/ready
// backpressure: stage 1 normalises, stage 2 rounds into the output register.
module fp_norm_round_pipe
  import fp_pipe_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int          BIAS  = 2**(EXP_W-1) - 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic                   in_carry,
  input  logic [MAN_W+2:0]       in_sig,
  input  logic                   in_sticky,
  input  logic [1:0]             in_rm,
  input  logic                   in_special,
  input  logic [EXP_W+MAN_W:0]   in_special_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_inexact
);

  localparam int unsigned SIG_W = MAN_W + 3;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned M_W   = MAN_W + 2;
  localparam int unsigned LZ_W  = $clog2(SIG_W + 1);
  localparam logic [E_W-1:0] EXP_ALL_ONES = E_W'((2**EXP_W) - 1);

  typedef `FP_WORD_T(EXP_W, MAN_W) fpWord_t;

  biasCheck: assert property (@(posedge clk) BIAS == (2**(EXP_W-1)) - 1);

  // Stage 1 may move into the output register when it is empty or draining.
  logic s2Advance;
  logic s1Valid;
  assign s2Advance = !out_valid | out_ready;
  assign in_ready  = !s1Valid | s2Advance;

  // ---------------- stage 1: normalise ----------------
  logic [LZ_W-1:0]  lz;
  logic [E_W-1:0]   expIn, shiftAmt, nExp;
  logic [SIG_W-1:0] nSig;
  logic             nSticky, nZero, nSign;

  fp_lzc #(.W(SIG_W)) uLzc (
    .value (in_sig),
    .count (lz)
  );

  always_comb begin
    expIn    = E_W'(in_exp);
    shiftAmt = '0;
    nSig     = in_sig;
    nExp     = expIn;
    nSticky  = in_sticky;
    nZero    = 1'b0;
    nSign    = in_sign;
    if (in_carry) begin
      nSig    = {1'b1, in_sig[SIG_W-1:1]};
      nSticky = in_sticky | in_sig[0];
      nExp    = expIn + E_W'(1);
    end else if (in_sig == '0) begin
      nZero = 1'b1;
      nSign = (rm_e'(in_rm) == RDN);
    end else begin
      // Shift is capped so the exponent bottoms out at 1 (subnormal encoding).
      shiftAmt = (E_W'(lz) < expIn - E_W'(1)) ? E_W'(lz) : expIn - E_W'(1);
      nSig     = in_sig << shiftAmt;
      nExp     = expIn - shiftAmt;
    end
  end

  logic             s1Sign, s1Sticky, s1Zero, s1Special;
  logic [E_W-1:0]   s1Exp;
  logic [SIG_W-1:0] s1Sig;
  rm_e              s1Rm;
  fpWord_t          s1SpecialVal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid      <= 1'b0;
      s1Sign       <= 1'b0;
      s1Exp        <= '0;
      s1Sig        <= '0;
      s1Sticky     <= 1'b0;
      s1Rm         <= RNE;
      s1Zero       <= 1'b0;
      s1Special    <= 1'b0;
      s1SpecialVal <= '0;
    end else if (in_ready) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1Sign       <= nSign;
        s1Exp        <= nExp;
        s1Sig        <= nSig;
        s1Sticky     <= nSticky;
        s1Rm         <= rm_e'(in_rm);
        s1Zero       <= nZero;
        s1Special    <= in_special;
        s1SpecialVal <= fpWord_t'(in_special_val);
      end
    end
  end

  // ---------------- stage 2: round ----------------
  logic             g, r, ovf, inx, unf, toInf;
  logic [M_W-1:0]   mant;
  logic [E_W-1:0]   rExp;
  logic [MAN_W-1:0] rFrac;
  fpWord_t          res;

  always_comb begin
    g     = s1Sig[1];
    r     = s1Sig[0];
    mant  = {1'b0, s1Sig[SIG_W-1:2]}
          + M_W'(round_incr(s1Rm, s1Sign, s1Sig[2], g, r, s1Sticky));
    rFrac = mant[MAN_W-1:0];
    rExp  = mant[MAN_W] ? s1Exp : '0;
    if (mant[M_W-1]) begin
      rFrac = '0;
      rExp  = s1Exp + E_W'(1);
    end
    ovf   = (rExp >= EXP_ALL_ONES);
    inx   = g | r | s1Sticky | ovf;
    unf   = (rExp == '0) & inx;
    toInf = (s1Rm == RNE) | ((s1Rm == RUP) & !s1Sign) | ((s1Rm == RDN) & s1Sign);
    res.sign = s1Sign;
    res.exp  = rExp[EXP_W-1:0];
    res.frac = rFrac;
    if (ovf) begin
      res.exp  = toInf ? {EXP_W{1'b1}} : {{(EXP_W-1){1'b1}}, 1'b0};
      res.frac = toInf ? {MAN_W{1'b0}} : {MAN_W{1'b1}};
    end
    if (s1Zero) begin
      res      = '0;
      res.sign = s1Sign;
      ovf      = 1'b0;
      inx      = 1'b0;
      unf      = 1'b0;
    end
    if (s1Special) begin
      res = s1SpecialVal;
      ovf = 1'b0;
      inx = 1'b0;
      unf = 1'b0;
    end
  end

  // Output register only loads a real beat, so a stalled result stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2Advance) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_result    <= res;
        out_overflow  <= ovf;
        out_underflow <= unf;
        out_inexact   <= inx;
      end
    end
  end

endmodule
